maze_solve: RTL

Wall-following maze solver that sits directly upstream of the navigation FSM. It issues one-cycle `strt_mv` / `strt_hdng` pulses together with `stp_lft` / `stp_rght` and a desired heading, then waits for `mv_cmplt`. After each completed forward move it samples the IR openings, picks the next heading by left- or right-hand affinity, and repeats until the magnet-found indication ends the solve.

---
 rtl/maze_solve.sv | 69 ++++++
 1 files changed

// File: rtl/maze_solve.sv
// maze_solve: wall-following maze solver issuing move/heading commands to navigation
`timescale 1ns/1ps
module maze_solve (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_md,
  input  logic        cmd0,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        mv_cmplt,
  input  logic        sol_cmplt,
  output logic        strt_mv,
  output logic        strt_hdng,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic [11:0] dsrd_hdng,
  output logic        solved,
  output logic [7:0]  mv_cnt
);
  typedef enum logic [2:0] {IDLE, MV_ISSUE, MV_WAIT, HDNG_ISSUE, HDNG_WAIT, DONE} state_t;
  state_t state, nxt;
  logic [1:0] dir, turn_dir;
  logic aff, pick_l, pick_r, mv_done, start, moving;
  always_comb begin
    pick_l = aff ? lft_opn : lft_opn & ~rght_opn;
    pick_r = aff ? rght_opn & ~lft_opn : rght_opn;
    turn_dir = pick_l ? dir + 2'd1 : pick_r ? dir - 2'd1 : dir + 2'd2;
    start = state == IDLE && cmd_md && !sol_cmplt;
    mv_done = state == MV_WAIT && mv_cmplt && cmd_md;
    nxt = state;
    if (state != IDLE && !cmd_md) nxt = IDLE;
    else
      case (state)
        IDLE:       nxt = start ? MV_ISSUE : IDLE;
        MV_ISSUE:   nxt = MV_WAIT;
        MV_WAIT:    nxt = !mv_cmplt ? MV_WAIT : sol_cmplt ? DONE : HDNG_ISSUE;
        HDNG_ISSUE: nxt = HDNG_WAIT;
        HDNG_WAIT:  nxt = !mv_cmplt ? HDNG_WAIT : sol_cmplt ? DONE : MV_ISSUE;
        default:    nxt = DONE;
      endcase
  end
  assign moving    = state == MV_ISSUE || state == MV_WAIT;
  assign strt_mv   = state == MV_ISSUE;
  assign stp_lft   = moving && aff;
  assign stp_rght  = moving && !aff;
  assign solved    = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= 2'd0;
      aff       <= 1'b1;
      dsrd_hdng <= 12'h000;
      mv_cnt    <= 8'd0;
      strt_hdng <= 1'b0;
    end else begin
      state     <= nxt;
      strt_hdng <= state == HDNG_ISSUE && cmd_md;
      dsrd_hdng <= dir == 2'd0 ? 12'h000 : dir == 2'd1 ? 12'h3FF : dir == 2'd2 ? 12'h7FF : 12'hC00;
      if (start) begin
        aff    <= cmd0;
        mv_cnt <= 8'd0;
      end
      if (mv_done) begin
        mv_cnt <= mv_cnt + {7'd0, mv_cnt != 8'hFF};
        if (!sol_cmplt) dir <= turn_dir;
      end
    end
  end
endmodule
